// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder exposing reg_num 32-bit control registers as a flat bus with per-register write pulses.
// Optional byte-strobe writes are enabled by defining AXI4_LITE_SLAVE_WSTRB_EN.
module axi4_lite_slave_regs #(
  parameter int datawidth = 32,
  parameter int addrwidth = 32,
  parameter int reg_num   = 16
) (
  input  logic                          s_axi_aclk_in,
  input  logic                          s_axi_areset_in,
  input  logic [addrwidth-1:0]          s_axi_awaddr_in,
  input  logic                          s_axi_awvalid_in,
  output logic                          s_axi_awready_out,
  input  logic [datawidth-1:0]          s_axi_wdata_in,
  input  logic [datawidth/8-1:0]        s_axi_wstrb_in,
  input  logic                          s_axi_wvalid_in,
  output logic                          s_axi_wready_out,
  output logic [1:0]                    s_axi_bresp_out,
  output logic                          s_axi_bvalid_out,
  input  logic                          s_axi_bready_in,
  input  logic [addrwidth-1:0]          s_axi_araddr_in,
  input  logic                          s_axi_arvalid_in,
  output logic                          s_axi_arready_out,
  output logic [datawidth-1:0]          s_axi_rdata_out,
  output logic [1:0]                    s_axi_rresp_out,
  output logic                          s_axi_rvalid_out,
  input  logic                          s_axi_rready_in,
  output logic [reg_num*datawidth-1:0]  reg_bank_out,
  output logic [reg_num-1:0]            reg_wr_pulse_out
);

  localparam int IDXW = (reg_num > 1) ? $clog2(reg_num) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [datawidth-1:0]   regs [reg_num];
  logic                   aw_held;
  logic                   w_held;
  logic [addrwidth-1:0]   aw_addr;
  logic [datawidth-1:0]   w_data;
  logic                   bvalid;
  logic [1:0]             bresp;
  logic                   rvalid;
  logic [1:0]             rresp;
  logic [datawidth-1:0]   rdata;
  logic [reg_num-1:0]     wr_pulse;
  logic [datawidth-1:0]   wr_word;
  logic [IDXW-1:0]        widx;
  logic [IDXW-1:0]        ridx;
  logic                   aw_hs;
  logic                   w_hs;
  logic                   ar_hs;
  logic                   commit;

  // Full-width compare so high address bits can never alias onto a register.
  function automatic logic in_range(input logic [addrwidth-1:0] a);
    return a < addrwidth'(reg_num * 4);
  endfunction

  assign s_axi_awready_out = ~s_axi_areset_in & ~aw_held & ~bvalid;
  assign s_axi_wready_out  = ~s_axi_areset_in & ~w_held & ~bvalid;
  assign s_axi_arready_out = ~s_axi_areset_in & ~rvalid;
  assign s_axi_bvalid_out  = bvalid;
  assign s_axi_bresp_out   = bresp;
  assign s_axi_rvalid_out  = rvalid;
  assign s_axi_rresp_out   = rresp;
  assign s_axi_rdata_out   = rdata;
  assign reg_wr_pulse_out  = wr_pulse;

  assign aw_hs  = s_axi_awvalid_in & s_axi_awready_out;
  assign w_hs   = s_axi_wvalid_in & s_axi_wready_out;
  assign ar_hs  = s_axi_arvalid_in & s_axi_arready_out;
  assign commit = aw_held & w_held & ~bvalid;
  assign widx   = aw_addr[IDXW+1:2];
  assign ridx   = s_axi_araddr_in[IDXW+1:2];

`ifdef AXI4_LITE_SLAVE_WSTRB_EN
  logic [datawidth/8-1:0] w_strb;

  always_ff @(posedge s_axi_aclk_in) begin
    if (s_axi_areset_in) begin
      w_strb <= '0;
    end else if (w_hs) begin
      w_strb <= s_axi_wstrb_in;
    end
  end

  always_comb begin
    wr_word = regs[widx];
    for (int unsigned b = 0; b < datawidth / 8; b++) begin
      if (w_strb[b]) wr_word[b*8 +: 8] = w_data[b*8 +: 8];
    end
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^s_axi_wstrb_in;

  always_comb begin
    wr_word = w_data;
  end
`endif

  always_ff @(posedge s_axi_aclk_in) begin
    if (s_axi_areset_in) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      rvalid   <= 1'b0;
      rresp    <= RESP_OKAY;
      rdata    <= '0;
      wr_pulse <= '0;
      for (int unsigned i = 0; i < reg_num; i++) regs[i] <= '0;
    end else begin
      wr_pulse <= '0;

      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= s_axi_awaddr_in;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata_in;
      end

      // Ready terms exclude held flags, so a commit never races a new AW/W capture.
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        if (in_range(aw_addr)) begin
          regs[widx]     <= wr_word;
          wr_pulse[widx] <= 1'b1;
          bresp          <= RESP_OKAY;
        end else begin
          bresp <= RESP_SLVERR;
        end
      end else if (bvalid & s_axi_bready_in) begin
        bvalid <= 1'b0;
      end

      // Non-blocking read of regs yields the pre-commit value on a coincident write.
      if (ar_hs) begin
        rvalid <= 1'b1;
        if (in_range(s_axi_araddr_in)) begin
          rdata <= regs[ridx];
          rresp <= RESP_OKAY;
        end else begin
          rdata <= '0;
          rresp <= RESP_SLVERR;
        end
      end else if (rvalid & s_axi_rready_in) begin
        rvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    reg_bank_out = '0;
    for (int unsigned i = 0; i < reg_num; i++) begin
      reg_bank_out[i*datawidth +: datawidth] = regs[i];
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed plus randomized bench for axi4_lite_slave_regs against an array-based register model.
module tb_axi4_lite_slave_regs;
  localparam int RN = 16;

  logic              clk = 1'b0;
  logic              areset;
  logic [31:0]       awaddr, wdata, araddr;
  logic [3:0]        wstrb;
  logic              awvalid, wvalid, bready, arvalid, rready;
  logic              awready, wready, bvalid, arready, rvalid;
  logic [1:0]        bresp, rresp;
  logic [31:0]       rdata;
  logic [RN*32-1:0]  bank;
  logic [RN-1:0]     pulse;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [RN];

  always #5 clk = ~clk;

  axi4_lite_slave_regs #(.datawidth(32), .addrwidth(32), .reg_num(RN)) dut (
    .s_axi_aclk_in(clk), .s_axi_areset_in(areset),
    .s_axi_awaddr_in(awaddr), .s_axi_awvalid_in(awvalid), .s_axi_awready_out(awready),
    .s_axi_wdata_in(wdata), .s_axi_wstrb_in(wstrb), .s_axi_wvalid_in(wvalid),
    .s_axi_wready_out(wready), .s_axi_bresp_out(bresp), .s_axi_bvalid_out(bvalid),
    .s_axi_bready_in(bready), .s_axi_araddr_in(araddr), .s_axi_arvalid_in(arvalid),
    .s_axi_arready_out(arready), .s_axi_rdata_out(rdata), .s_axi_rresp_out(rresp),
    .s_axi_rvalid_out(rvalid), .s_axi_rready_in(rready),
    .reg_bank_out(bank), .reg_wr_pulse_out(pulse)
  );

  task automatic check(input string tag, input logic [RN*32-1:0] obs, input logic [RN*32-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RN*32-1:0] bank_exp();
    logic [RN*32-1:0] r;
    for (int i = 0; i < RN; i++) r[i*32 +: 32] = model[i];
    return r;
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    return a < 32'(RN * 4);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    if (!addr_ok(a)) return;
    idx = int'(a) / 4;
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
    for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
`else
    model[idx] = d;
`endif
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_hs, w_hs;
    int cyc = 0;
    logic [RN-1:0] exp_pulse;
    exp_pulse = '0;
    if (addr_ok(a)) exp_pulse[int'(a) / 4] = 1'b1;
    awaddr = a; wdata = d; wstrb = s;
    bready = (b_dly == 0);
    while (!(aw_done && w_done) && cyc < 40) begin
      if (cyc == aw_dly) awvalid = 1'b1;
      if (cyc == w_dly)  wvalid  = 1'b1;
      if (w_done)  check("wready_after_w", wready, 0);
      if (aw_done) check("awready_after_aw", awready, 0);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1; wvalid  = 1'b0; end
      cyc++;
    end
    check("aw_w_handshake", aw_done && w_done, 1);
    check("bvalid_before_commit", bvalid, 0);
    check("bank_before_commit", bank, bank_exp());
    model_write(a, d, s);
    tick();
    check("bvalid_rise", bvalid, 1);
    check("bresp", bresp, addr_ok(a) ? 2'b00 : 2'b10);
    check("wr_pulse", pulse, exp_pulse);
    check("bank_after_commit", bank, bank_exp());
    for (int k = 0; k < b_dly; k++) begin
      check("awready_during_b", awready, 0);
      check("wready_during_b", wready, 0);
      tick();
      check("bvalid_held", bvalid, 1);
      check("wr_pulse_one_cycle", pulse, 0);
    end
    bready = 1'b1;
    tick();
    check("bvalid_clear", bvalid, 0);
    check("wr_pulse_clear", pulse, 0);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, input int r_dly);
    logic [31:0] exp_d;
    exp_d = addr_ok(a) ? model[int'(a[31:2]) % RN] : 32'h0;
    araddr = a; arvalid = 1'b1;
    rready = (r_dly == 0);
    check("arready_idle", arready, 1);
    tick();
    arvalid = 1'b0;
    check("rvalid_rise", rvalid, 1);
    check("rdata", rdata, exp_d);
    check("rresp", rresp, addr_ok(a) ? 2'b00 : 2'b10);
    for (int k = 0; k < r_dly; k++) begin
      check("arready_busy", arready, 0);
      tick();
      check("rvalid_held", rvalid, 1);
      check("rdata_held", rdata, exp_d);
    end
    check("arready_at_clear", arready, 0);
    rready = 1'b1;
    tick();
    check("rvalid_clear", rvalid, 0);
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    areset = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < RN; i++) model[i] = '0;
    tick(); tick();
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bank", bank, 0);
    check("rst_pulse", pulse, 0);
    areset = 1'b0;
    #1;
    check("idle_awready", awready, 1);
    check("idle_wready", wready, 1);
    check("idle_arready", arready, 1);

    axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("reg2_deadbeef", bank[95:64], 32'hDEADBEEF);
    axi_read(32'h08, 0);

    axi_write(32'h00, 32'h12345678, 4'hF, 3, 0, 4);
    check("reg0_12345678", bank[31:0], 32'h12345678);

    axi_write(32'h40, 32'h55555555, 4'hF, 1, 0, 1);
    axi_read(32'h40, 1);
    axi_write(32'h1040, 32'h66666666, 4'hF, 0, 2, 0);
    axi_read(32'h1040, 0);

    // Write commit on the same edge as an AR to the same register.
    axi_write(32'h0C, 32'h11111111, 4'hF, 0, 0, 0);
    awaddr = 32'h0C; wdata = 32'h22222222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h0C; arvalid = 1'b1;
    check("coincident_arready", arready, 1);
    tick();
    arvalid = 1'b0;
    model[3] = 32'h22222222;
    check("coincident_rvalid", rvalid, 1);
    check("coincident_bvalid", bvalid, 1);
    check("coincident_rdata_old", rdata, 32'h11111111);
    check("coincident_bank_new", bank, bank_exp());
    rready = 1'b1;
    tick();
    check("coincident_rvalid_clear", rvalid, 0);
    check("coincident_bvalid_clear", bvalid, 0);
    rready = 1'b0; bready = 1'b0;
    axi_read(32'h0C, 0);

    axi_write(32'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    axi_write(32'h04, 32'h00000000, 4'b0101, 0, 1, 0);
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
    check("wstrb_merge", bank[63:32], 32'hAA00CC00);
`else
    check("wstrb_ignored", bank[63:32], 32'h00000000);
`endif
    axi_write(32'h04, 32'hFFFFFFFF, 4'b0000, 2, 0, 0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0)
        a = 32'(RN * 4) + 32'($urandom_range(0, 1100)) * 4;
      else
        a = 32'($urandom_range(0, RN - 1)) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 1) == 0)
        axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3));
      else
        axi_read(a, $urandom_range(0, 3));
    end

    // Reset while a read is pending and an AW is held.
    araddr = 32'h00; arvalid = 1'b1;
    awaddr = 32'h08; awvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    check("pre_reset_rvalid", rvalid, 1);
    areset = 1'b1;
    #1;
    check("reset_forces_awready", awready, 0);
    tick();
    areset = 1'b0;
    for (int i = 0; i < RN; i++) model[i] = '0;
    check("post_reset_rvalid", rvalid, 0);
    check("post_reset_bank", bank, 0);
    check("post_reset_pulse", pulse, 0);
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("no_stale_aw_commit", bvalid, 0);
    end
    awaddr = 32'h10; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    model_write(32'h10, 32'hCAFEF00D, 4'hF);
    check("late_aw_bvalid", bvalid, 1);
    check("late_aw_pulse", pulse, 16'h0010);
    check("late_aw_bank", bank, bank_exp());
    bready = 1'b1;
    tick();
    bready = 1'b0;
    axi_read(32'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
